// File: rtl/token_bucket_injector_if.sv
// Switch-input handshake bundle between a token_bucket_injector and the PE port of torus_switch_bp.
interface token_bucket_injector_if #(
  parameter int VC_W = 3,
  parameter int X_W  = 2,
  parameter int Y_W  = 2,
  parameter int D_W  = 256
) ();

  logic             i_ack;
  logic             i_v;
  logic [VC_W-1:0]  i_vc;
  logic [X_W-1:0]   i_x;
  logic [Y_W-1:0]   i_y;
  logic [D_W-1:0]   i_data;

  modport master (
    input  i_ack,
    output i_v,
    output i_vc,
    output i_x,
    output i_y,
    output i_data
  );

  modport slave (
    output i_ack,
    input  i_v,
    input  i_vc,
    input  i_x,
    input  i_y,
    input  i_data
  );

endinterface

// File: rtl/token_bucket_injector.sv
// Token-bucket shaped packet source: bursts up to SIGMA packets, then one per RATE cycles,
// holding each packet on the switch input until it is acknowledged.
module token_bucket_injector #(
  parameter int SIGMA     = 3,
  parameter int RATE      = 20,
  parameter int VC_W      = 3,
  parameter int X_W       = 2,
  parameter int Y_W       = 2,
  parameter int D_W       = 256,
  parameter int X         = 0,
  parameter int Y         = 0,
  parameter int N_PACKETS = 128,
  parameter int X_MAX     = 1 << X_W,
  parameter int Y_MAX     = 1 << Y_W
) (
  input  logic                     clk,
  input  logic                     rst,
  token_bucket_injector_if.master  sw,
  output logic                     done
);

  localparam int RC_W   = (RATE > 1) ? $clog2(RATE) : 1;
  localparam int TOK_W  = (SIGMA > 0) ? $clog2(SIGMA + 1) : 1;
  localparam int TOKX_W = TOK_W + 1;
  localparam int CNT_W  = (N_PACKETS > 0) ? $clog2(N_PACKETS + 1) : 1;
  localparam int CNTX_W = CNT_W + 1;
  localparam int NODES  = X_MAX * Y_MAX;
  localparam int NODE_W = $clog2(NODES) + 1;
  localparam int SELF   = Y * X_MAX + X;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [RC_W-1:0]   rc;
  logic [TOK_W-1:0]  tok;
  logic [TOK_W-1:0]  tok_next;
  logic [TOKX_W-1:0] tok_sum;
  logic [CNT_W-1:0]  sent;
  logic [CNT_W-1:0]  acked;
  logic [NODE_W-1:0] off;
  logic [NODE_W-1:0] dest_sum;
  logic [NODE_W-1:0] dest;
  logic [X_W-1:0]    x_next;
  logic [Y_W-1:0]    y_next;
  logic [D_W-1:0]    data_next;
  logic              tick;
  logic              load;
  logic              ack_seen;
  logic              last_ack;

  assign tick     = (rc == RC_W'(RATE - 1));
  assign ack_seen = sw.i_v && sw.i_ack;
  assign load     = (tok != '0) && (sent < CNT_W'(N_PACKETS)) && (!sw.i_v || sw.i_ack);
  assign last_ack = ({1'b0, acked} + CNTX_W'(1)) >= CNTX_W'(N_PACKETS);

  // A load always has a token behind it, so the sum never underflows; only the top needs clamping.
  always_comb begin
    tok_sum  = {1'b0, tok} + TOKX_W'(tick) - TOKX_W'(load);
    tok_next = (tok_sum > TOKX_W'(SIGMA)) ? TOK_W'(SIGMA) : tok_sum[TOK_W-1:0];
  end

  // off stays in 1..NODES-1, so SELF+off wraps at most once and never lands on this node.
  always_comb begin
    dest_sum = NODE_W'(SELF) + off;
    dest     = (dest_sum >= NODE_W'(NODES)) ? (dest_sum - NODE_W'(NODES)) : dest_sum;
    x_next   = X_W'(dest % NODE_W'(X_MAX));
    y_next   = Y_W'(dest / NODE_W'(X_MAX));
  end

  always_comb begin
    data_next        = '0;
    data_next[15:0]  = 16'(sent);
    data_next[23:16] = 8'(X);
    data_next[31:24] = 8'(Y);
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (acked >= CNT_W'(N_PACKETS)) begin
          state_next = ST_DONE;
        end else if (load) begin
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (sw.i_ack && !load) begin
          state_next = last_ack ? ST_DONE : ST_IDLE;
        end
      end
      ST_DONE: state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Valid and done are registered copies of the next-state decode, so every output comes from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      rc        <= '0;
      tok       <= TOK_W'(SIGMA);
      sent      <= '0;
      acked     <= '0;
      off       <= NODE_W'(1);
      done      <= 1'b0;
      sw.i_v    <= 1'b0;
      sw.i_vc   <= '0;
      sw.i_x    <= '0;
      sw.i_y    <= '0;
      sw.i_data <= '0;
    end else begin
      state  <= state_next;
      sw.i_v <= (state_next == ST_SEND);
      done   <= (state_next == ST_DONE);
      rc     <= tick ? '0 : (rc + RC_W'(1));
      tok    <= tok_next;
      if (ack_seen) begin
        acked <= acked + CNT_W'(1);
      end
      if (load) begin
        sent      <= sent + CNT_W'(1);
        off       <= (off == NODE_W'(NODES - 1)) ? NODE_W'(1) : (off + NODE_W'(1));
        sw.i_vc   <= VC_W'(sent);
        sw.i_x    <= x_next;
        sw.i_y    <= y_next;
        sw.i_data <= data_next;
      end
    end
  end

  a_hold_valid : assert property (@(posedge clk) disable iff (!rst)
    (sw.i_v && !sw.i_ack) |=> sw.i_v);

  a_hold_fields : assert property (@(posedge clk) disable iff (!rst)
    (sw.i_v && !sw.i_ack) |=> ($stable(sw.i_data) && $stable(sw.i_vc)
                               && $stable(sw.i_x) && $stable(sw.i_y)));

  a_done_sticky : assert property (@(posedge clk) disable iff (!rst)
    done |=> done);

  a_tok_range : assert property (@(posedge clk) disable iff (!rst)
    tok <= TOK_W'(SIGMA));

  a_done_quiet : assert property (@(posedge clk) disable iff (!rst)
    done |-> !sw.i_v);

  if (NODES > 1) begin : g_self_chk
    a_not_self : assert property (@(posedge clk) disable iff (!rst)
      sw.i_v |-> !((sw.i_x == X_W'(X)) && (sw.i_y == Y_W'(Y))));
  end

endmodule

// File: tb/tb_token_bucket_injector.sv
// Directed bench: burst/refill timing, backpressure, destinations, payload, completion and async reset.
module tb_token_bucket_injector;

  logic clk;
  logic rst_a;
  logic rst_o;
  logic done_a, done_b, done_c, done_d;
  int   errors;
  int   checks;

  logic        a_v    [1:45];
  logic [1:0]  a_x1, a_y1, a_x21, a_y21;
  logic [15:0] a_d21;
  logic [1:0]  b_x    [0:19];
  logic [1:0]  b_y    [0:19];
  logic [2:0]  b_vc   [0:19];
  logic [31:0] b_data [0:19];
  logic        b_v    [0:19];
  logic        c_v    [1:10];
  logic        c_done [1:10];
  logic        d_v    [1:3];
  logic        d_done [1:3];
  int          a_count;
  int          a_low;

  token_bucket_injector_if #(.VC_W(3), .X_W(2), .Y_W(2), .D_W(256)) sw_a ();
  token_bucket_injector_if #(.VC_W(3), .X_W(2), .Y_W(2), .D_W(256)) sw_b ();
  token_bucket_injector_if #(.VC_W(3), .X_W(2), .Y_W(2), .D_W(256)) sw_c ();
  token_bucket_injector_if #(.VC_W(3), .X_W(2), .Y_W(2), .D_W(256)) sw_d ();

  token_bucket_injector #(.SIGMA(3), .RATE(20), .X(0), .Y(0), .N_PACKETS(128)) dut_a (
    .clk(clk), .rst(rst_a), .sw(sw_a), .done(done_a));
  token_bucket_injector #(.SIGMA(3), .RATE(1), .X(1), .Y(2), .N_PACKETS(20)) dut_b (
    .clk(clk), .rst(rst_o), .sw(sw_b), .done(done_b));
  token_bucket_injector #(.SIGMA(1), .RATE(1), .X(0), .Y(0), .N_PACKETS(5)) dut_c (
    .clk(clk), .rst(rst_o), .sw(sw_c), .done(done_c));
  token_bucket_injector #(.SIGMA(3), .RATE(20), .X(0), .Y(0), .N_PACKETS(0)) dut_d (
    .clk(clk), .rst(rst_o), .sw(sw_d), .done(done_d));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clk = 1'b0;
    rst_a = 1'b0;
    rst_o = 1'b0;
    errors = 0;
    checks = 0;
    sw_a.i_ack = 1'b0;
    sw_b.i_ack = 1'b1;
    sw_c.i_ack = 1'b1;
    sw_d.i_ack = 1'b1;
    stepCycle();
    stepCycle();

    checkOutput("rst_a_v", sw_a.i_v, 0);
    checkOutput("rst_a_data", sw_a.i_data[63:0], 0);
    checkOutput("rst_a_tok", dut_a.tok, 3);
    checkOutput("rst_d_done", done_d, 0);

    // Burst on A, destinations on B, completion on C, empty run on D.
    sw_a.i_ack = 1'b1;
    rst_a = 1'b1;
    rst_o = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      stepCycle();
      a_v[n] = sw_a.i_v;
      if (n == 1) begin
        a_x1 = sw_a.i_x;
        a_y1 = sw_a.i_y;
      end
      if (n == 21) begin
        a_x21 = sw_a.i_x;
        a_y21 = sw_a.i_y;
        a_d21 = sw_a.i_data[15:0];
      end
      if (n <= 20) begin
        b_x[n-1]    = sw_b.i_x;
        b_y[n-1]    = sw_b.i_y;
        b_vc[n-1]   = sw_b.i_vc;
        b_data[n-1] = sw_b.i_data[31:0];
        b_v[n-1]    = sw_b.i_v;
      end
      if (n <= 10) begin
        c_v[n]    = sw_c.i_v;
        c_done[n] = done_c;
      end
      if (n <= 3) begin
        d_v[n]    = sw_d.i_v;
        d_done[n] = done_d;
      end
    end

    checkOutput("a_v_c1", a_v[1], 1);
    checkOutput("a_v_c2", a_v[2], 1);
    checkOutput("a_v_c3", a_v[3], 1);
    checkOutput("a_v_c4", a_v[4], 0);
    checkOutput("a_v_c20", a_v[20], 0);
    checkOutput("a_v_c21", a_v[21], 1);
    checkOutput("a_v_c22", a_v[22], 0);
    checkOutput("a_v_c40", a_v[40], 0);
    checkOutput("a_v_c41", a_v[41], 1);
    a_count = 0;
    for (int n = 1; n <= 45; n++) a_count += int'(a_v[n]);
    checkOutput("a_pkt_count", a_count, 5);
    checkOutput("a_p0_x", a_x1, 1);
    checkOutput("a_p0_y", a_y1, 0);
    checkOutput("a_p3_idx", a_d21, 3);
    checkOutput("a_p3_x", a_x21, 0);
    checkOutput("a_p3_y", a_y21, 1);

    checkOutput("b_p0_xy", {b_x[0], b_y[0]}, {2'd2, 2'd2});
    checkOutput("b_p1_xy", {b_x[1], b_y[1]}, {2'd3, 2'd2});
    checkOutput("b_p2_xy", {b_x[2], b_y[2]}, {2'd0, 2'd3});
    checkOutput("b_p14_xy", {b_x[14], b_y[14]}, {2'd0, 2'd2});
    checkOutput("b_p15_xy", {b_x[15], b_y[15]}, {2'd2, 2'd2});
    checkOutput("b_p9_vc", b_vc[9], 1);
    checkOutput("b_p8_vc", b_vc[8], 0);
    checkOutput("b_p9_data", b_data[9], 32'h0201_0009);
    for (int k = 0; k < 20; k++) begin
      checkOutput("b_valid", b_v[k], 1);
      checkOutput("b_not_self", (b_x[k] == 2'd1) && (b_y[k] == 2'd2), 0);
    end

    for (int n = 1; n <= 5; n++) checkOutput("c_v_burst", c_v[n], 1);
    checkOutput("c_done_c5", c_done[5], 0);
    checkOutput("c_done_c6", c_done[6], 1);
    checkOutput("c_v_c6", c_v[6], 0);
    checkOutput("c_done_c10", c_done[10], 1);
    checkOutput("d_done_c1", d_done[1], 1);
    checkOutput("d_v_c1", d_v[1], 0);
    checkOutput("d_done_c3", d_done[3], 1);

    // Backpressure on A: packet 0 frozen for 50 cycles while the bucket refills.
    rst_a = 1'b0;
    sw_a.i_ack = 1'b0;
    stepCycle();
    rst_a = 1'b1;
    a_low = 0;
    for (int n = 1; n <= 50; n++) begin
      stepCycle();
      if (!sw_a.i_v) a_low++;
    end
    checkOutput("bp_v_low_cycles", a_low, 0);
    checkOutput("bp_p0_idx", sw_a.i_data[15:0], 0);
    checkOutput("bp_p0_xy", {sw_a.i_x, sw_a.i_y}, {2'd1, 2'd0});
    checkOutput("bp_tok_full", dut_a.tok, 3);
    sw_a.i_ack = 1'b1;
    stepCycle();
    checkOutput("bp_c51_idx", sw_a.i_data[15:0], 1);
    stepCycle();
    checkOutput("bp_c52_idx", sw_a.i_data[15:0], 2);
    stepCycle();
    checkOutput("bp_c53_idx", sw_a.i_data[15:0], 3);
    checkOutput("bp_c53_v", sw_a.i_v, 1);
    stepCycle();
    checkOutput("bp_c54_v", sw_a.i_v, 0);
    checkOutput("bp_c54_tok", dut_a.tok, 0);
    checkOutput("bp_c54_acked", dut_a.acked, 4);

    // Asynchronous reset while a packet is being presented.
    rst_a = 1'b0;
    stepCycle();
    rst_a = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("mr_pre_v", sw_a.i_v, 1);
    checkOutput("mr_pre_idx", sw_a.i_data[15:0], 1);
    #2;
    rst_a = 1'b0;
    #1;
    checkOutput("mr_v", sw_a.i_v, 0);
    checkOutput("mr_vc", sw_a.i_vc, 0);
    checkOutput("mr_xy", {sw_a.i_x, sw_a.i_y}, 0);
    checkOutput("mr_data", sw_a.i_data[63:0], 0);
    checkOutput("mr_done", done_a, 0);
    checkOutput("mr_tok", dut_a.tok, 3);
    stepCycle();
    rst_a = 1'b1;
    stepCycle();
    checkOutput("mr_post_v", sw_a.i_v, 1);
    checkOutput("mr_post_idx", sw_a.i_data[15:0], 0);
    checkOutput("mr_post_tok", dut_a.tok, 2);
    stepCycle();
    checkOutput("mr_post_idx1", sw_a.i_data[15:0], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
